// File: rtl/mppt_pwm_ctrl_if.sv
// Sample stream between the converter front end and the MPPT controller.
// The front end is the master: it presents paired voltage/current samples
// and the controller takes one on every cycle where valid and ready are both high.
interface mppt_pwm_ctrl_if #(
  parameter int DW = 8
) ();
  logic          sample_valid;
  logic          sample_ready;
  logic [DW-1:0] v_sample;
  logic [DW-1:0] i_sample;

  modport master (
    output sample_valid,
    output v_sample,
    output i_sample,
    input  sample_ready
  );

  modport slave (
    input  sample_valid,
    input  v_sample,
    input  i_sample,
    output sample_ready
  );
endinterface

// File: rtl/mppt_pwm_ctrl.sv
// Perturb-and-observe MPPT controller with PWM switch drive.
// Averages v*i over 2^AVG_LOG2 accepted samples, compares the average with the
// previous one, nudges the duty command by STEP in the direction that raised
// power, and turns the duty into a glitch-free PWM output.
module mppt_pwm_ctrl #(
  parameter int DW        = 8,
  parameter int PWM_BITS  = 8,
  parameter int AVG_LOG2  = 2,
  parameter int STEP      = 1,
  parameter int DUTY_MIN  = 16,
  parameter int DUTY_MAX  = 240,
  parameter int DUTY_INIT = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  mppt_pwm_ctrl_if.slave      sample,
  output logic                pwm_out,
  output logic [PWM_BITS-1:0] duty,
  output logic [2*DW-1:0]     power_avg,
  output logic                mppt_dir,
  output logic                update_pulse
);

  localparam int ACC_W = 2 * DW + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0]        LAST_IDX = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [PWM_BITS-1:0]     D_INIT   = PWM_BITS'(DUTY_INIT);
  localparam logic signed [PWM_BITS:0] D_MIN   = $signed((PWM_BITS + 1)'(DUTY_MIN));
  localparam logic signed [PWM_BITS:0] D_MAX   = $signed((PWM_BITS + 1)'(DUTY_MAX));
  localparam logic signed [PWM_BITS:0] D_STEP  = $signed((PWM_BITS + 1)'(STEP));

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_COMPARE,
    S_STEP
  } state_t;

  state_t                     state;
  logic [ACC_W-1:0]           acc;
  logic [CNT_W-1:0]           cnt;
  logic [2*DW-1:0]            prev_avg;
  logic                       ready;

  logic [2*DW-1:0]            prod;
  logic [2*DW-1:0]            avg_now;
  logic                       move;
  logic                       dir_eff;
  logic signed [PWM_BITS:0]   duty_s;
  logic signed [PWM_BITS:0]   duty_sum;
  logic [PWM_BITS-1:0]        duty_nxt;
  logic                       dir_nxt;

  logic [PWM_BITS-1:0]        pwm_cnt;
  logic [PWM_BITS-1:0]        duty_shadow;

  assign sample.sample_ready = ready;

  // Both operands widened first so the product keeps all 2*DW bits.
  assign prod   = (2 * DW)'(sample.v_sample) * (2 * DW)'(sample.i_sample);
  assign duty_s = $signed({1'b0, duty});

  // Perturb-and-observe decision for the average currently in the accumulator.
  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    avg_now  = (2 * DW)'(acc >> AVG_LOG2);
    move     = (avg_now != prev_avg);
    dir_eff  = (avg_now < prev_avg) ? ~mppt_dir : mppt_dir;
    duty_sum = dir_eff ? (duty_s + D_STEP) : (duty_s - D_STEP);
    duty_nxt = duty;
    dir_nxt  = dir_eff;
    // Signed headroom lets the step overshoot the limits without wrapping;
    // hitting a limit turns the search around.
    if (duty_sum > D_MAX) begin
      duty_nxt = D_MAX[PWM_BITS-1:0];
      dir_nxt  = ~dir_eff;
    end else if (duty_sum < D_MIN) begin
      duty_nxt = D_MIN[PWM_BITS-1:0];
      dir_nxt  = ~dir_eff;
    end else begin
      duty_nxt = duty_sum[PWM_BITS-1:0];
    end
  end

  // Control FSM: accumulate, average, then apply the step with registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      acc          <= '0;
      cnt          <= '0;
      prev_avg     <= '0;
      power_avg    <= '0;
      duty         <= D_INIT;
      mppt_dir     <= 1'b1;
      update_pulse <= 1'b0;
      ready        <= 1'b0;
    end else if (!enable) begin
      // Abort: restart the search from scratch, keep the last reported power.
      state        <= S_IDLE;
      acc          <= '0;
      cnt          <= '0;
      prev_avg     <= '0;
      duty         <= D_INIT;
      mppt_dir     <= 1'b1;
      update_pulse <= 1'b0;
      ready        <= 1'b0;
    end else begin
      update_pulse <= 1'b0;
      unique case (state)
        S_IDLE: begin
          state <= S_ACCUM;
          ready <= 1'b1;
        end
        S_ACCUM: begin
          if (sample.sample_valid && ready) begin
            acc <= acc + ACC_W'(prod);
            cnt <= cnt + 1'b1;
            if (cnt == LAST_IDX) begin
              state <= S_COMPARE;
              ready <= 1'b0;
            end
          end
        end
        S_COMPARE: begin
          // The decision is registered on entry to STEP so that duty, mppt_dir,
          // power_avg and update_pulse all change together in the STEP cycle.
          power_avg    <= avg_now;
          acc          <= '0;
          cnt          <= '0;
          update_pulse <= 1'b1;
          if (move) begin
            duty     <= duty_nxt;
            mppt_dir <= dir_nxt;
          end
          state <= S_STEP;
        end
        S_STEP: begin
          prev_avg <= power_avg;
          state    <= S_ACCUM;
          ready    <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          ready <= 1'b0;
        end
      endcase
    end
  end

  // Free-running PWM; the duty is latched only at the period boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt     <= '0;
      duty_shadow <= D_INIT;
      pwm_out     <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (pwm_cnt == '1) begin
        duty_shadow <= duty;
      end
      pwm_out <= enable && (pwm_cnt < duty_shadow);
    end
  end

endmodule

// File: tb/tb_mppt_pwm_ctrl.sv
// Bench for mppt_pwm_ctrl: a cycle model of the default instance checked every
// cycle, plus directed checks of the clamp instance and the PWM instance.
module tb_mppt_pwm_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_a = 1'b0, en_c = 1'b0, en_p = 1'b0;
  logic s_valid = 1'b0;
  logic [7:0] s_v = '0, s_i = '0;

  logic       pwm_a, dir_a, pulse_a, pwm_c, dir_c, pulse_c, pwm_p, dir_p, pulse_p;
  logic [7:0] duty_a, duty_c, duty_p;
  logic [15:0] pow_a, pow_c, pow_p;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mppt_pwm_ctrl_if #(.DW(8)) a_if ();
  mppt_pwm_ctrl_if #(.DW(8)) c_if ();
  mppt_pwm_ctrl_if #(.DW(8)) p_if ();

  assign a_if.sample_valid = s_valid;
  assign a_if.v_sample     = s_v;
  assign a_if.i_sample     = s_i;
  assign c_if.sample_valid = s_valid;
  assign c_if.v_sample     = s_v;
  assign c_if.i_sample     = s_i;
  assign p_if.sample_valid = s_valid;
  assign p_if.v_sample     = s_v;
  assign p_if.i_sample     = s_i;

  mppt_pwm_ctrl dut_a (
    .clk(clk), .rst(rst), .enable(en_a), .sample(a_if),
    .pwm_out(pwm_a), .duty(duty_a), .power_avg(pow_a),
    .mppt_dir(dir_a), .update_pulse(pulse_a)
  );

  mppt_pwm_ctrl #(.DUTY_INIT(239), .DUTY_MAX(240)) dut_c (
    .clk(clk), .rst(rst), .enable(en_c), .sample(c_if),
    .pwm_out(pwm_c), .duty(duty_c), .power_avg(pow_c),
    .mppt_dir(dir_c), .update_pulse(pulse_c)
  );

  mppt_pwm_ctrl #(.DUTY_INIT(64)) dut_p (
    .clk(clk), .rst(rst), .enable(en_p), .sample(p_if),
    .pwm_out(pwm_p), .duty(duty_p), .power_avg(pow_p),
    .mppt_dir(dir_p), .update_pulse(pulse_p)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out", name);
  endtask

  function automatic logic rdy(input int sel);
    case (sel)
      0:       return a_if.sample_ready;
      1:       return c_if.sample_ready;
      default: return p_if.sample_ready;
    endcase
  endfunction

  function automatic logic pls(input int sel);
    case (sel)
      0:       return pulse_a;
      1:       return pulse_c;
      default: return pulse_p;
    endcase
  endfunction

  // ---------------- behavioural model of dut_a (default parameters) -------
  // Transaction view: samples collected into a running sum, a decision two
  // clocks after the last one, two clocks with ready low, PWM by period index.
  int m_duty = 128, m_pow = 0, m_prev = 0, m_sum = 0, m_n = 0, m_wait = 0;
  int m_time = 0, m_shadow = 128;
  bit m_dir = 1'b1, m_pulse = 1'b0, m_ready = 1'b0, m_pwm = 1'b0;

  task automatic model_step();
    int avg, nd;
    if (rst) begin
      m_duty = 128; m_pow = 0; m_prev = 0; m_sum = 0; m_n = 0; m_wait = 0;
      m_time = 0; m_shadow = 128; m_dir = 1'b1; m_pulse = 1'b0;
      m_ready = 1'b0; m_pwm = 1'b0;
      return;
    end
    // PWM: high for the first shadow-duty cycles of each 256-cycle period.
    m_pwm = en_a && ((m_time % 256) < m_shadow);
    if ((m_time % 256) == 255) m_shadow = m_duty;
    m_time++;
    m_pulse = 1'b0;
    if (!en_a) begin
      m_sum = 0; m_n = 0; m_wait = 0; m_prev = 0; m_duty = 128; m_dir = 1'b1;
      m_ready = 1'b0;
    end else if (m_wait == 2) begin
      avg = m_sum / 4;
      m_pow = avg;
      if (avg != m_prev) begin
        if (avg < m_prev) m_dir = !m_dir;
        nd = m_dir ? m_duty + 1 : m_duty - 1;
        if (nd > 240) begin nd = 240; m_dir = !m_dir; end
        else if (nd < 16) begin nd = 16; m_dir = !m_dir; end
        m_duty = nd;
      end
      m_prev = avg; m_sum = 0; m_pulse = 1'b1; m_wait = 1;
    end else if (m_wait == 1) begin
      m_wait = 0; m_ready = 1'b1;
    end else if (!m_ready) begin
      m_ready = 1'b1;
    end else if (s_valid) begin
      m_sum += int'(s_v) * int'(s_i);
      m_n++;
      if (m_n == 4) begin m_n = 0; m_ready = 1'b0; m_wait = 2; end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      model_step();
    end
  end

  // Compare process: dut_a outputs against the model on every cycle.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("cyc_ready", 32'(a_if.sample_ready), 32'(m_ready));
      check("cyc_duty",  32'(duty_a),  32'(m_duty));
      check("cyc_power", 32'(pow_a),   32'(m_pow));
      check("cyc_dir",   32'(dir_a),   32'(m_dir));
      check("cyc_pulse", 32'(pulse_a), 32'(m_pulse));
      check("cyc_pwm",   32'(pwm_a),   32'(m_pwm));
    end
  end

  // High-run lengths of dut_p's PWM output.
  int runs_p[$];
  int cur_run = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (pwm_p === 1'b1) cur_run++;
      else if (cur_run > 0) begin
        runs_p.push_back(cur_run);
        cur_run = 0;
      end
    end
  end

  // ---------------- stimulus helpers (called at a falling edge) -----------
  task automatic send_sample(input int sel, input logic [7:0] v, input logic [7:0] i);
    bit ok = 1'b0;
    s_v = v; s_i = i; s_valid = 1'b1;
    for (int k = 0; k < 40 && !ok; k++) begin
      if (rdy(sel) === 1'b1) begin
        @(posedge clk);
        ok = 1'b1;
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    if (!ok) fail_now("send_sample");
  endtask

  task automatic send_n(input int sel, input int n, input logic [7:0] v, input logic [7:0] i);
    for (int k = 0; k < n; k++) send_sample(sel, v, i);
  endtask

  task automatic wait_pulse(input int sel);
    bit ok = 1'b0;
    for (int k = 0; k < 12 && !ok; k++) begin
      if (pls(sel) === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) fail_now("wait_pulse");
  endtask

  task automatic wait_pwm_rise();
    logic prev;
    bit ok = 1'b0;
    prev = pwm_p;
    for (int k = 0; k < 700 && !ok; k++) begin
      @(negedge clk);
      if (prev === 1'b0 && pwm_p === 1'b1) ok = 1'b1;
      prev = pwm_p;
    end
    if (!ok) fail_now("wait_pwm_rise");
  endtask

  // ---------------- directed sequence -----------------------------------
  initial begin
    int highs, seen;

    // 1 Reset with enable and samples active.
    en_a = 1'b1; s_valid = 1'b1; s_v = 8'd100; s_i = 8'd10;
    repeat (3) @(negedge clk);
    check("rst_pwm",   32'(pwm_a), 0);
    check("rst_duty",  32'(duty_a), 128);
    check("rst_power", 32'(pow_a), 0);
    check("rst_dir",   32'(dir_a), 1);
    check("rst_ready", 32'(a_if.sample_ready), 0);
    s_valid = 1'b0;
    rst = 1'b0;

    // 2 Rising power.
    send_n(0, 4, 8'd100, 8'd10);
    wait_pulse(0);
    check("rise1_power", 32'(pow_a), 1000);
    check("rise1_duty",  32'(duty_a), 129);
    @(negedge clk);
    check("rise1_pulse_once", 32'(pulse_a), 0);
    send_n(0, 4, 8'd100, 8'd12);
    wait_pulse(0);
    check("rise2_power", 32'(pow_a), 1200);
    check("rise2_duty",  32'(duty_a), 130);
    check("rise2_dir",   32'(dir_a), 1);

    // 3 Falling power, then equal power.
    send_n(0, 4, 8'd100, 8'd9);
    wait_pulse(0);
    check("fall_power", 32'(pow_a), 900);
    check("fall_dir",   32'(dir_a), 0);
    check("fall_duty",  32'(duty_a), 129);
    send_n(0, 4, 8'd100, 8'd9);
    wait_pulse(0);
    check("equal_duty", 32'(duty_a), 129);
    check("equal_dir",  32'(dir_a), 0);

    // 6 Abort after two samples, then a fresh batch of four.
    send_n(0, 2, 8'd100, 8'd10);
    en_a = 1'b0;
    @(negedge clk);
    check("abort_pwm",   32'(pwm_a), 0);
    check("abort_ready", 32'(a_if.sample_ready), 0);
    check("abort_duty",  32'(duty_a), 128);
    check("abort_power_held", 32'(pow_a), 900);
    en_a = 1'b1;
    send_n(0, 3, 8'd50, 8'd4);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (pulse_a === 1'b1) seen++;
    end
    check("abort_no_early_pulse", 32'(seen), 0);
    send_sample(0, 8'd50, 8'd4);
    wait_pulse(0);
    check("reen_power", 32'(pow_a), 200);
    check("reen_duty",  32'(duty_a), 129);

    // Asynchronous reset mid-accumulation.
    send_n(0, 2, 8'd100, 8'd10);
    #2 rst = 1'b1;
    #1;
    check("arst_duty",  32'(duty_a), 128);
    check("arst_power", 32'(pow_a), 0);
    check("arst_ready", 32'(a_if.sample_ready), 0);
    check("arst_pwm",   32'(pwm_a), 0);
    en_a = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // 4 Clamp at DUTY_MAX.
    en_c = 1'b1;
    send_n(1, 4, 8'd100, 8'd10);
    wait_pulse(1);
    check("clamp1_duty", 32'(duty_c), 240);
    check("clamp1_dir",  32'(dir_c), 1);
    send_n(1, 4, 8'd100, 8'd12);
    wait_pulse(1);
    check("clamp2_duty",  32'(duty_c), 240);
    check("clamp2_dir",   32'(dir_c), 0);
    check("clamp2_power", 32'(pow_c), 1200);
    en_c = 1'b0;
    @(negedge clk);

    // 5 PWM high time and period-aligned duty change.
    en_p = 1'b1;
    wait_pwm_rise();
    highs = 0;
    for (int k = 0; k < 256; k++) begin
      if (pwm_p === 1'b1) highs++;
      @(negedge clk);
    end
    check("pwm_high_64", 32'(highs), 64);
    send_n(2, 3, 8'd100, 8'd10);
    wait_pwm_rise();
    runs_p.delete();
    send_sample(2, 8'd100, 8'd10);
    wait_pulse(2);
    check("pwm_duty_65", 32'(duty_p), 65);
    seen = 0;
    for (int k = 0; k < 700 && runs_p.size() < 2; k++) @(negedge clk);
    if (runs_p.size() < 2) fail_now("pwm_runs");
    else begin
      check("pwm_run_midchange", 32'(runs_p[0]), 64);
      check("pwm_run_next",      32'(runs_p[1]), 65);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
